retire_drain_ctrl: RTL and testbench
====================================

Name: retire_drain_ctrl

Overview:
- Controller that sequences the NRET lockstep per-commit-port ingress FIFOs of the multiple-retirement path.
- Walks the valid slots of the head group in ascending port order and presents one slot per handshake to the serial itype/encoder pipeline.
- Pops all FIFOs once the group is fully drained.
- Replaces free-running counter muxing with a backpressure-aware valid/ready scheduler.

Parameters:
- NRET, 2, number of commit ports / slots per FIFO group (>=1).
- SEL_W, (NRET>1 ? $clog2(NRET) : 1), width of slot select (derived, not overridden).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- flush_i  in  1  synchronous abort of the current group; FIFOs are flushed externally.
- empty_i  in  1  port-0 FIFO empty. FIFOs are pushed in lockstep, so this represents all ports.
- slot_valid_i  in  NRET  valid bit of each FIFO head entry.
- out_ready_i  in  1  downstream accepts the selected entry.
- out_valid_o  out  1  selected entry is valid.
- sel_o  out  SEL_W  port index of the selected head entry (drives the datapath mux).
- last_o  out  1  selected slot is the highest valid slot of the group.
- pop_o  out  1  pop all ingress FIFOs this cycle.
- busy_o  out  1  a group is being served.

Behaviour:
- Reset values: state=IDLE, cur_q=0, mask_q=0. All outputs 0.
- States: IDLE, SERVE.
- IDLE, empty_i=1: all outputs 0.
- IDLE, empty_i=0, slot_valid_i==0: pop_o=1 for one cycle (discard the empty group). Stay in IDLE.
- IDLE, empty_i=0, slot_valid_i!=0: mask_q<=slot_valid_i; cur_q<=lowest set index; go to SERVE next cycle. No output this cycle.
- SERVE: out_valid_o=1, sel_o=cur_q, busy_o=1.
- SERVE: last_o=1 iff mask_q has no set bit above cur_q.
- Handshake occurs when out_valid_o && out_ready_i.
- Handshake, not last: cur_q<=next set index above cur_q in mask_q. Stay in SERVE.
- Handshake, last: pop_o=1 in the same cycle; go to IDLE. Next group is served earliest 2 cycles later (one evaluation bubble).
- No handshake: hold cur_q, sel_o, last_o and out_valid_o stable (AXI-style rule: valid never drops without a handshake).
- mask_q is captured once per group; slot_valid_i is ignored in SERVE.
- flush_i has highest priority, in any state:
  - next state IDLE, cur_q<=0, mask_q<=0;
  - pop_o=0 and out_valid_o=0 in the flush cycle (combinationally gated);
  - any handshake in that cycle is void.
- NRET=1: sel_o is constantly 0 and last_o=1 whenever out_valid_o=1.
- Async reset mid-SERVE: immediate return to the reset values. The group is not popped.

Optional Feature:
- Macro: MURE_DRAIN_STATS_EN.
- With the macro, adds outputs:
  - served_cnt_o, 32-bit: increments per handshake;
  - stall_cnt_o, 32-bit: increments per SERVE cycle with out_ready_i=0;
  - drop_cnt_o, 16-bit: increments per empty-group discard.
- All counters saturate at max, reset to 0, are unaffected by flush_i, and are cleared by stats_clr_i (extra 1-bit input; clear wins over increment).
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- mure_pkg gets:
  - drain_state_e enum (IDLE, SERVE);
  - NRET (reused);
  - DRAIN_SEL_W localparam;
  - STATS_CNT_W=32 and DROP_CNT_W=16.
- Sub-module find_next_set: combinational priority search returning the lowest set bit of mask at index > from (plus a from=-1 mode for first-set) and a found flag. Used twice: first-slot search and next-slot/last_o.

Test Plan:
- NRET=2, empty_i=0, slot_valid_i=2'b11, out_ready_i=1 -> cycle+1: out_valid_o=1, sel_o=0, last_o=0; cycle+2: sel_o=1, last_o=1, pop_o=1; cycle+3: out_valid_o=0.
- slot_valid_i=2'b10, out_ready_i=1 -> single beat sel_o=1, last_o=1, pop_o=1 with that beat; slot 0 is never selected.
- slot_valid_i=2'b00, empty_i=0 for 1 cycle -> pop_o=1 that cycle, out_valid_o stays 0; with MURE_DRAIN_STATS_EN, drop_cnt_o=1.
- slot_valid_i=2'b11, out_ready_i=0 for 5 cycles then 1 -> sel_o=0 held stable for 5 cycles; pop_o=0 until the slot-1 handshake; stall_cnt_o=5 when stats enabled.
- flush_i=1 in SERVE while out_ready_i=1 -> out_valid_o=0, pop_o=0 that cycle; next cycle state IDLE, busy_o=0; the next group starts from slot 0.
- rst_ni asserted low asynchronously mid-SERVE -> outputs 0 before the next clock edge; after release, IDLE and no pop.

Source files
------------

// File: rtl/mure_pkg.sv
// mure_pkg: shared types and sizes for the multiple-retirement drain path
package mure_pkg;
  localparam int NRET = 2;
  localparam int DRAIN_SEL_W = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int STATS_CNT_W = 32;
  localparam int DROP_CNT_W = 16;
  typedef enum logic {IDLE, SERVE} drain_state_e;
endpackage

// File: rtl/find_next_set.sv
// find_next_set: lowest set bit of mask above index from, or lowest set bit overall when first=1
// Ports: mask/from/first in; idx (found index, 0 if none) and found out.
module find_next_set #(
  parameter int W = 2,
  parameter int SW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  input  logic [SW-1:0] from,
  input  logic          first,
  output logic [SW-1:0] idx,
  output logic          found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--)
      if (mask[i] && (first || i > int'(from))) begin
        idx = SW'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/retire_drain_ctrl.sv
// retire_drain_ctrl: serialises the valid slots of the head commit group onto a valid/ready port, then pops all FIFOs
// Ports: clk_i, rst_ni (async active-low), flush_i, empty_i, slot_valid_i[NRET], out_ready_i in;
//        out_valid_o, sel_o[SEL_W], last_o, pop_o, busy_o out.
// MURE_DRAIN_STATS_EN adds stats_clr_i in and served_cnt_o, stall_cnt_o, drop_cnt_o saturating counters out.
module retire_drain_ctrl #(
  parameter int NRET = mure_pkg::NRET,
  localparam int SEL_W = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             empty_i,
  input  logic [NRET-1:0]  slot_valid_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             last_o,
  output logic             pop_o,
  output logic             busy_o
`ifdef MURE_DRAIN_STATS_EN
  ,
  input  logic                             stats_clr_i,
  output logic [mure_pkg::STATS_CNT_W-1:0] served_cnt_o,
  output logic [mure_pkg::STATS_CNT_W-1:0] stall_cnt_o,
  output logic [mure_pkg::DROP_CNT_W-1:0]  drop_cnt_o
`endif
);
  import mure_pkg::*;
  drain_state_e state_q, state_d;
  logic [SEL_W-1:0] cur_q, cur_d, first_idx, next_idx;
  logic [NRET-1:0] mask_q, mask_d;
  logic any_valid, more, serve, hs, discard;
  find_next_set #(.W(NRET), .SW(SEL_W)) u_first (
    .mask(slot_valid_i), .from('0), .first(1'b1), .idx(first_idx), .found(any_valid)
  );
  // no higher slot left in the captured mask means the current slot is the last one
  find_next_set #(.W(NRET), .SW(SEL_W)) u_next (
    .mask(mask_q), .from(cur_q), .first(1'b0), .idx(next_idx), .found(more)
  );
  always_comb begin
    serve = state_q == SERVE;
    out_valid_o = serve && !flush_i;
    sel_o = serve ? cur_q : '0;
    last_o = serve && !more;
    busy_o = serve;
    hs = out_valid_o && out_ready_i;
    discard = !serve && !flush_i && !empty_i && !any_valid;
    pop_o = discard || (hs && !more);
    state_d = state_q;
    cur_d = cur_q;
    mask_d = mask_q;
    if (flush_i) begin
      state_d = IDLE;
      cur_d = '0;
      mask_d = '0;
    end else if (!serve) begin
      if (!empty_i && any_valid) begin
        state_d = SERVE;
        cur_d = first_idx;
        mask_d = slot_valid_i;
      end
    end else if (hs) begin
      if (more) cur_d = next_idx;
      else state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      mask_q <= mask_d;
    end
`ifdef MURE_DRAIN_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      served_cnt_o <= '0;
      stall_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else if (stats_clr_i) begin
      served_cnt_o <= '0;
      stall_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (hs && !(&served_cnt_o)) served_cnt_o <= served_cnt_o + 1'b1;
      if (serve && !out_ready_i && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (discard && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_retire_drain_ctrl.sv
// tb_retire_drain_ctrl: directed and random checks of retire_drain_ctrl against a queue-based model of the drain order
module tb_retire_drain_ctrl;
  logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, empty_i = 1'b1, out_ready_i = 1'b0;
  logic [1:0] slot_valid_i = 2'b00;
  logic out_valid_o, last_o, pop_o, busy_o;
  logic [0:0] sel_o;
`ifdef MURE_DRAIN_STATS_EN
  logic stats_clr_i = 1'b0;
  logic [31:0] served_cnt_o, stall_cnt_o;
  logic [15:0] drop_cnt_o;
`endif
  int vectors = 0, miscompares = 0;
  int q[$];
  bit m_busy = 1'b0;
  int served = 0, stalls = 0, drops = 0;

  retire_drain_ctrl #(.NRET(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .empty_i(empty_i),
    .slot_valid_i(slot_valid_i), .out_ready_i(out_ready_i),
    .out_valid_o(out_valid_o), .sel_o(sel_o), .last_o(last_o), .pop_o(pop_o), .busy_o(busy_o)
`ifdef MURE_DRAIN_STATS_EN
    , .stats_clr_i(stats_clr_i), .served_cnt_o(served_cnt_o), .stall_cnt_o(stall_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step(input logic f, input logic e, input logic [1:0] sv, input logic r);
    bit ev, el, ep, hs;
    int es;
    flush_i = f;
    empty_i = e;
    slot_valid_i = sv;
    out_ready_i = r;
    @(negedge clk_i);
    ev = m_busy && !f;
    es = m_busy ? q[0] : 0;
    el = m_busy && q.size() == 1;
    hs = ev && r;
    ep = m_busy ? (hs && el) : (!f && !e && sv == 2'b00);
    chk("out_valid", out_valid_o, ev);
    chk("sel", sel_o, es);
    chk("last", last_o, el);
    chk("pop", pop_o, ep);
    chk("busy", busy_o, m_busy);
`ifdef MURE_DRAIN_STATS_EN
    chk("served_cnt", served_cnt_o, served);
    chk("stall_cnt", stall_cnt_o, stalls);
    chk("drop_cnt", drop_cnt_o, drops);
`endif
    @(posedge clk_i);
`ifdef MURE_DRAIN_STATS_EN
    if (stats_clr_i) begin
      served = 0;
      stalls = 0;
      drops = 0;
    end else begin
      served += int'(hs);
      stalls += int'(m_busy && !r);
      drops += int'(!m_busy && ep);
    end
`endif
    if (f) begin
      m_busy = 1'b0;
      q.delete();
    end else if (m_busy) begin
      if (hs) begin
        void'(q.pop_front());
        if (q.size() == 0) m_busy = 1'b0;
      end
    end else if (!e && sv != 2'b00) begin
      for (int i = 0; i < 2; i++) if (sv[i]) q.push_back(i);
      m_busy = 1'b1;
    end
    #1;
  endtask

  initial begin
    #2;
    chk("reset_valid", out_valid_o, 0);
    chk("reset_pop", pop_o, 0);
    chk("reset_busy", busy_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step(0, 1, 2'b11, 1);
    // both slots, ready: slot 0 then slot 1 with pop, then idle
    step(0, 0, 2'b11, 1);
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    // only slot 1 valid
    step(0, 0, 2'b10, 1);
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    // empty group discard
    step(0, 0, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    // backpressure for 5 cycles
    step(0, 0, 2'b11, 0);
    repeat (5) step(0, 1, 2'b00, 0);
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    // flush while the downstream is ready, then a fresh group starts at slot 0
    step(0, 0, 2'b11, 1);
    step(0, 1, 2'b00, 1);
    step(1, 1, 2'b00, 1);
    step(0, 0, 2'b11, 1);
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    // asynchronous reset in the middle of a group
    step(0, 0, 2'b11, 0);
    step(0, 1, 2'b00, 0);
    empty_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_o, 0);
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_pop", pop_o, 0);
    chk("async_rst_last", last_o, 0);
    m_busy = 1'b0;
    q.delete();
    served = 0;
    stalls = 0;
    drops = 0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    repeat (400) begin
`ifdef MURE_DRAIN_STATS_EN
      stats_clr_i = $urandom_range(0, 31) == 0;
`endif
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, 2'($urandom), 1'($urandom));
    end
`ifdef MURE_DRAIN_STATS_EN
    stats_clr_i = 1'b0;
`endif
    step(0, 1, 2'b00, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
